// File: rtl/mux_rr_sched_pkg.sv
// mux_rr_sched_pkg
// Shared constants, FSM state encoding and index helper for the round-robin
// mux scheduler (mux_rr_sched) and its pick sub-block (rr_pick).
//   N_REQ     : number of requesters / mux inputs
//   DW        : data width per block
//   SEL_W     : width of a requester index / mux select
//   MAX_BURST : longest run of consecutive beats to one requester when the
//               optional burst mode (MUX_RR_SCHED_BURST_EN) is compiled in
package mux_rr_sched_pkg;

    localparam int N_REQ     = 10;
    localparam int DW        = 8;
    localparam int SEL_W     = 4;
    localparam int MAX_BURST = 4;
    localparam int BURST_W   = 2;

    // IDLE: output slot empty. HOLD: slot full, waiting for out_ready.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Next index in round-robin order, wrapping N_REQ-1 back to 0.
    // Anything at or beyond the last index also maps to 0 so an index can
    // never escape the legal range.
    function automatic logic [SEL_W-1:0] idx_wrap(input logic [SEL_W-1:0] i);
        if (i >= SEL_W'(N_REQ - 1)) begin
            return '0;
        end
        return i + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux_rr_sched_rr_pick.sv
// rr_pick
// Combinational round-robin search. Starting one past the last-granted
// index, walks the request vector in circular order and reports the first
// requester found.
//   req   : per-requester request bits
//   ptr   : last-granted index (search starts at ptr+1)
//   found : at least one request is asserted
//   k     : index of the chosen requester (0 when nothing is found)
module rr_pick
    import mux_rr_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] k
);

    logic [SEL_W-1:0] idx;

    // N_REQ steps cover every index exactly once, ending back on ptr itself,
    // so ptr is picked again only when nobody else is asking.
    always_comb begin
        found = 1'b0;
        k     = '0;
        idx   = ptr;
        for (int step = 0; step < N_REQ; step++) begin
            idx = idx_wrap(idx);
            if (!found && req[idx]) begin
                found = 1'b1;
                k     = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// mux_rr_sched
// Round-robin scheduler sharing a 10-way 8-bit block mux among 10
// requesters. One requesting block is accepted per loadable cycle; its byte
// and select code are registered into a single-stage valid/ready slot.
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset
//   req       : per-requester request
//   req_data  : flattened block data, block i at [i*DW +: DW]
//   gnt       : one-hot combinational accept of the beat consumed this cycle
//   out_valid : slot holds a beat
//   out_ready : downstream accepts the beat
//   out_data  : registered selected byte
//   out_sel   : registered select of the beat in the slot
//   busy      : out_valid or any request pending
// Optional feature: define MUX_RR_SCHED_BURST_EN to let the last-granted
// requester keep the mux for up to MAX_BURST consecutive beats.
module mux_rr_sched
    import mux_rr_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic [SEL_W-1:0]    out_sel,
    output logic                busy
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [N_REQ-1:0] gnt_d;

    logic             found;
    logic [SEL_W-1:0] k;
    logic             can_load;
    logic             sel_found;
    logic [SEL_W-1:0] sel_k;
    logic [DW-1:0]    sel_data;

`ifdef MUX_RR_SCHED_BURST_EN
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               burst_hit;
`endif

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (found),
        .k     (k)
    );

    assign can_load = (state_q == IDLE) || out_ready;

    // Final choice of requester: in burst mode the current owner keeps the
    // mux while it still asks and has budget left, otherwise plain rotation.
    always_comb begin
`ifdef MUX_RR_SCHED_BURST_EN
        burst_hit = req[ptr_q] && (burst_cnt_q < BURST_W'(MAX_BURST - 1));
        sel_found = burst_hit || found;
        sel_k     = burst_hit ? ptr_q : k;
`else
        sel_found = found;
        sel_k     = k;
`endif
    end

    // Mux steering: pull the chosen block's byte out of the flattened bus.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_k == SEL_W'(i)) begin
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Accept and next-state logic. A grant is only issued when the slot can
    // take the beat, and never while reset is asserted.
    always_comb begin
        gnt_d      = '0;
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
`ifdef MUX_RR_SCHED_BURST_EN
        burst_cnt_d = burst_cnt_q;
`endif
        if (can_load) begin
            if (sel_found) begin
                if (!rst) begin
                    gnt_d[sel_k] = 1'b1;
                end
                out_data_d = sel_data;
                out_sel_d  = sel_k;
                ptr_d      = sel_k;
                state_d    = HOLD;
`ifdef MUX_RR_SCHED_BURST_EN
                burst_cnt_d = burst_hit ? (burst_cnt_q + BURST_W'(1)) : '0;
`endif
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= SEL_W'(N_REQ - 1);
            out_data_q <= '0;
            out_sel_q  <= '0;
`ifdef MUX_RR_SCHED_BURST_EN
            burst_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
`ifdef MUX_RR_SCHED_BURST_EN
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    assign gnt       = gnt_d;
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign busy      = out_valid | (|req);

endmodule

// File: tb/tb_mux_rr_sched.sv
// tb_mux_rr_sched
// Self-checking bench for mux_rr_sched: directed scenarios followed by
// randomized traffic, compared against a behavioural round-robin model.
module tb_mux_rr_sched;

    localparam int NR = 10;
    localparam int W  = 8;
    localparam int MAXB = 4;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     gnt;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [3:0]        out_sel;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // Reference model: occupancy of the slot, its contents, last winner
    // and how many extra beats the last winner has taken in a row.
    bit       mValid;
    bit [7:0] mData;
    int       mSel;
    int       mLast;
    int       mBurst;

    mux_rr_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mValid = 0;
        mData  = 8'h00;
        mSel   = 0;
        mLast  = NR - 1;
        mBurst = 0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs mid-cycle,
    // advance the model on the edge, then check the registered outputs.
    task automatic applyStimulus(input logic r, input logic [NR-1:0] rq,
                                 input logic [NR*W-1:0] dat, input logic rdy);
        int  pick;
        bit  burstHit;
        logic [NR-1:0] expGnt;
        rst       = r;
        req       = rq;
        req_data  = dat;
        out_ready = rdy;
        pick      = -1;
        burstHit  = 0;
        if (!mValid || rdy) begin
`ifdef MUX_RR_SCHED_BURST_EN
            if (rq[mLast] && mBurst < MAXB - 1) begin
                burstHit = 1;
                pick     = mLast;
            end
`endif
            if (pick < 0) begin
                for (int s = 1; s <= NR; s++) begin
                    if (pick < 0 && rq[(mLast + s) % NR]) pick = (mLast + s) % NR;
                end
            end
        end
        expGnt = '0;
        if (!r && pick >= 0) expGnt[pick] = 1'b1;
        #4;
        checkOutput("gnt", 32'(gnt), 32'(expGnt));
        checkOutput("busy", 32'(busy), 32'(mValid | (|rq)));
        @(posedge clk);
        if (r) begin
            modelReset();
        end else if (!mValid || rdy) begin
            if (pick >= 0) begin
                mData  = dat[pick*W +: W];
                mSel   = pick;
                mValid = 1;
                mBurst = burstHit ? mBurst + 1 : 0;
                mLast  = pick;
            end else begin
                mValid = 0;
            end
        end
        #1;
        checkOutput("out_valid", 32'(out_valid), 32'(mValid));
        checkOutput("out_data", 32'(out_data), 32'(mData));
        checkOutput("out_sel", 32'(out_sel), 32'(mSel));
    endtask

    function automatic logic [NR*W-1:0] randData();
        logic [NR*W-1:0] d;
        for (int i = 0; i < NR; i++) d[i*W +: W] = 8'($urandom);
        return d;
    endfunction

    // Each block's byte is {block index in high nibble offset, index}.
    function automatic logic [NR*W-1:0] tagData();
        logic [NR*W-1:0] d;
        for (int i = 0; i < NR; i++) d[i*W +: W] = 8'(8'h10 * i + i);
        d[2*W +: W] = 8'hA2;
        d[9*W +: W] = 8'hB9;
        d[5*W +: W] = 8'h55;
        return d;
    endfunction

    initial begin
        int expSeq[8];
        logic [NR-1:0] rq;
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        modelReset();

        $display("[TB] reset state");
        applyStimulus(1'b1, '0, tagData(), 1'b0);

        $display("[TB] all requesters, full throughput");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 10'h3FF, tagData(), 1'b1);
            checkOutput("seq_all", 32'(out_sel), 32'(i % NR));
        end

        $display("[TB] blocks 2 and 9 alternate");
        applyStimulus(1'b1, '0, tagData(), 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 10'b10_0000_0100, tagData(), 1'b1);
            checkOutput("alt_data", 32'(out_data), (i % 2 == 0) ? 32'hA2 : 32'hB9);
        end

        $display("[TB] stall on block 5");
        applyStimulus(1'b1, '0, tagData(), 1'b1);
        applyStimulus(1'b0, 10'b00_0010_0000, tagData(), 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 10'b00_1110_0000, tagData(), 1'b0);
            checkOutput("stall_data", 32'(out_data), 32'h55);
        end
        applyStimulus(1'b0, 10'b00_1110_0000, tagData(), 1'b1);
        checkOutput("after_stall", 32'(out_sel), 32'd6);

        $display("[TB] wrap from 9 to 0");
        applyStimulus(1'b0, 10'b10_0000_0000, tagData(), 1'b1);
        applyStimulus(1'b0, 10'b00_0000_0001, tagData(), 1'b1);
        checkOutput("wrap_sel", 32'(out_sel), 32'd0);
        applyStimulus(1'b0, '0, tagData(), 1'b1);
        applyStimulus(1'b0, '0, tagData(), 1'b1);

        $display("[TB] reset while holding");
        applyStimulus(1'b0, 10'b00_1000_0000, tagData(), 1'b0);
        applyStimulus(1'b1, 10'b00_1001_0000, tagData(), 1'b0);
        applyStimulus(1'b0, 10'b00_1001_0000, tagData(), 1'b1);
        checkOutput("post_rst_sel", 32'(out_sel), 32'd4);

        $display("[TB] two steady requesters");
`ifdef MUX_RR_SCHED_BURST_EN
        expSeq = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        expSeq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        applyStimulus(1'b1, '0, tagData(), 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 10'h003, tagData(), 1'b1);
            checkOutput("pair_seq", 32'(out_sel), 32'(expSeq[i]));
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            rq = 10'($urandom);
            if ($urandom_range(0, 2) == 0) rq = rq & 10'($urandom);
            if ($urandom_range(0, 9) == 0) rq = '0;
            applyStimulus(($urandom_range(0, 59) == 0), rq, randData(),
                          ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
